// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: clears registers 1..31 after reset,
// then arbitrates core writeback, debug and MDU writes onto WE3/A3/WD3.
module regfile_write_arbiter #(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 5,
   parameter logic [DATA_W-1:0] CLEAR_VAL    = 32'h0000_0000,
   parameter int                STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_data,
   output logic              core_stall,
   input  logic              dbg_valid,
   output logic              dbg_ready,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_addr,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              init_done
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
   typedef enum logic {RR_DBG = 1'b0, RR_MDU = 1'b1} rr_t;

   localparam logic [3:0]        LIMIT_C    = 4'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] LAST_REG_C = {ADDR_W{1'b1}};

   state_t            state_r, state_nxt_s;
   rr_t               rr_ptr_r, rr_ptr_nxt_s;
   logic [ADDR_W-1:0] clr_idx_r, clr_idx_nxt_s;
   logic [3:0]        starve_r, starve_nxt_s;

   logic       in_init_s;
   logic       side_any_s;
   logic       starve_hit_s;
   logic       grant_core_s, grant_dbg_s, grant_mdu_s;
   logic [4:0] starve_diff_s;

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_INIT;
         clr_idx_r <= {{(ADDR_W-1){1'b0}}, 1'b1};
         rr_ptr_r  <= RR_DBG;
         starve_r  <= 4'd0;
      end else begin
         state_r   <= state_nxt_s;
         clr_idx_r <= clr_idx_nxt_s;
         rr_ptr_r  <= rr_ptr_nxt_s;
         starve_r  <= starve_nxt_s;
      end
   end

   // Grant selection and write-port drive; a reset cycle behaves like INIT
   always_comb begin
      in_init_s     = (!rst_n) || (state_r == ST_INIT);
      side_any_s    = dbg_valid || mdu_valid;
      // sign bit of (starve - limit) clear means starve >= limit
      starve_diff_s = {1'b0, starve_r} - {1'b0, LIMIT_C};
      starve_hit_s  = !starve_diff_s[4];
      grant_core_s  = 1'b0;
      grant_dbg_s   = 1'b0;
      grant_mdu_s   = 1'b0;
      core_stall    = 1'b0;
      rf_we         = 1'b0;
      rf_addr       = {ADDR_W{1'b0}};
      rf_data       = {DATA_W{1'b0}};
      if (in_init_s) begin
         core_stall = 1'b1;
         rf_we      = 1'b1;
         rf_addr    = clr_idx_r;
         rf_data    = CLEAR_VAL;
      end else begin
         core_stall = starve_hit_s && side_any_s;
         if (core_we && !core_stall) begin
            grant_core_s = 1'b1;
         end else if (dbg_valid && mdu_valid) begin
            if (rr_ptr_r == RR_DBG) begin
               grant_dbg_s = 1'b1;
            end else begin
               grant_mdu_s = 1'b1;
            end
         end else if (dbg_valid) begin
            grant_dbg_s = 1'b1;
         end else if (mdu_valid) begin
            grant_mdu_s = 1'b1;
         end else begin
            grant_core_s = 1'b0;
         end
         if (grant_core_s) begin
            rf_addr = core_addr;
            rf_data = core_data;
         end else if (grant_dbg_s) begin
            rf_addr = dbg_addr;
            rf_data = dbg_data;
         end else if (grant_mdu_s) begin
            rf_addr = mdu_addr;
            rf_data = mdu_data;
         end else begin
            rf_addr = {ADDR_W{1'b0}};
         end
         // register 0 is hardwired: the handshake completes but nothing is written
         rf_we = (grant_core_s || grant_dbg_s || grant_mdu_s) && (rf_addr != {ADDR_W{1'b0}});
      end
      dbg_ready = grant_dbg_s;
      mdu_ready = grant_mdu_s;
      init_done = !in_init_s;
   end

   // Next-state: clear sequencing, round-robin pointer and starvation counter
   always_comb begin
      state_nxt_s   = state_r;
      clr_idx_nxt_s = clr_idx_r;
      rr_ptr_nxt_s  = rr_ptr_r;
      starve_nxt_s  = starve_r;
      case (state_r)
         ST_INIT: begin
            clr_idx_nxt_s = clr_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (clr_idx_r == LAST_REG_C) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN: begin
            if (grant_dbg_s) begin
               rr_ptr_nxt_s = RR_MDU;
            end else if (grant_mdu_s) begin
               rr_ptr_nxt_s = RR_DBG;
            end else begin
               rr_ptr_nxt_s = rr_ptr_r;
            end
            if (grant_dbg_s || grant_mdu_s || !side_any_s) begin
               starve_nxt_s = 4'd0;
            end else if (grant_core_s && (starve_r != 4'hF)) begin
               starve_nxt_s = starve_r + 4'd1;
            end else begin
               starve_nxt_s = starve_r;
            end
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: default instance plus a STARVE_LIMIT=0 instance.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic        core_we, dbg_valid, mdu_valid;
   logic [4:0]  core_addr, dbg_addr, mdu_addr;
   logic [31:0] core_data, dbg_data, mdu_data;
   logic        core_stall, dbg_ready, mdu_ready, rf_we, init_done;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   logic        l0_core_we, l0_dbg_valid, l0_mdu_valid;
   logic [4:0]  l0_core_addr, l0_dbg_addr, l0_mdu_addr;
   logic [31:0] l0_core_data, l0_dbg_data, l0_mdu_data;
   logic        l0_core_stall, l0_dbg_ready, l0_mdu_ready, l0_rf_we, l0_init_done;
   logic [4:0]  l0_rf_addr;
   logic [31:0] l0_rf_data;

   int vectors;
   int miscompares;

   regfile_write_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .core_we(core_we), .core_addr(core_addr), .core_data(core_data), .core_stall(core_stall),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .init_done(init_done)
   );

   regfile_write_arbiter #(.STARVE_LIMIT(0)) u_l0 (
      .clk(clk), .rst_n(rst_n),
      .core_we(l0_core_we), .core_addr(l0_core_addr), .core_data(l0_core_data), .core_stall(l0_core_stall),
      .dbg_valid(l0_dbg_valid), .dbg_ready(l0_dbg_ready), .dbg_addr(l0_dbg_addr), .dbg_data(l0_dbg_data),
      .mdu_valid(l0_mdu_valid), .mdu_ready(l0_mdu_ready), .mdu_addr(l0_mdu_addr), .mdu_data(l0_mdu_data),
      .rf_we(l0_rf_we), .rf_addr(l0_rf_addr), .rf_data(l0_rf_data), .init_done(l0_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Walk the 31 clear cycles starting at the current negedge, then check the first RUN cycle
   task automatic run_clear(input string tag);
      logic [39:0] obs, exp;
      for (int i = 1; i <= 31; i++) begin
         if (i > 1) @(negedge clk);
         #1;
         obs = {rf_we, rf_addr, rf_data, init_done, core_stall};
         exp = {1'b1, 5'(i), 32'h0000_0000, 1'b0, 1'b1};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s clear cycle %0d: got %h expected %h", tag, i, obs, exp);
         end
         vectors++;
         if (dbg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s dbg_ready in init cycle %0d: got %b expected 0", tag, i, dbg_ready);
         end
      end
      @(negedge clk);
      core_we   = 1'b0;
      dbg_valid = 1'b0;
      #1;
      vectors++;
      if ({init_done, core_stall, rf_we, l0_init_done} !== 4'b1001) begin
         miscompares++;
         $display("FAIL %s init_done cycle 32: got %b expected 1001", tag,
                  {init_done, core_stall, rf_we, l0_init_done});
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n     = 1'b0;
      core_we   = 1'b1;
      core_addr = 5'd3;
      core_data = 32'hAAAA_5555;
      dbg_valid = 1'b1;
      dbg_addr  = 5'd4;
      dbg_data  = 32'h1111_2222;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if ({init_done, core_stall, dbg_ready, mdu_ready} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d: got %b expected 0100", c,
                     {init_done, core_stall, dbg_ready, mdu_ready});
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      run_clear("reset_clear");
   endtask

   task automatic test_mid_init_reset;
      logic [4:0] a;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         #1;
         a = rf_addr;
         vectors++;
         if (a !== 5'(i)) begin
            miscompares++;
            $display("FAIL midinit_pre addr: got %0d expected %0d", a, i);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({init_done, core_stall} !== 2'b01) begin
         miscompares++;
         $display("FAIL midinit_reset outputs: got %b expected 01", {init_done, core_stall});
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_clear("midinit_restart");
   endtask

   task automatic test_round_robin;
      logic [4:0]  exp_addr [6];
      logic [31:0] exp_data [6];
      logic [2:0]  exp_rdy  [6];
      logic [38:0] obs, exp;
      int          di, mi;
      exp_addr = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
      exp_data = '{32'hD000_0001, 32'hA000_0004, 32'hD000_0002, 32'hA000_0005, 32'hD000_0003, 32'hA000_0006};
      exp_rdy  = '{3'b110, 3'b101, 3'b110, 3'b101, 3'b110, 3'b101};
      di = 0;
      mi = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         dbg_valid = (di < 3);
         dbg_addr  = 5'(1 + di);
         dbg_data  = 32'hD000_0001 + 32'(di);
         mdu_valid = (mi < 3);
         mdu_addr  = 5'(4 + mi);
         mdu_data  = 32'hA000_0004 + 32'(mi);
         #1;
         obs = {rf_we, rf_addr, rf_data, dbg_ready};
         exp = {1'b1, exp_addr[c], exp_data[c], exp_rdy[c][1]};
         vectors++;
         if (obs !== exp || mdu_ready !== exp_rdy[c][0]) begin
            miscompares++;
            $display("FAIL round_robin cycle %0d: got %h/%b expected %h/%b", c, obs, mdu_ready,
                     exp, exp_rdy[c][0]);
         end
         if (exp_rdy[c][1]) di++;
         if (exp_rdy[c][0]) mi++;
      end
      @(negedge clk);
      dbg_valid = 1'b0;
      mdu_valid = 1'b0;
   endtask

   task automatic test_reg0;
      @(negedge clk);
      dbg_valid = 1'b1;
      dbg_addr  = 5'd0;
      dbg_data  = 32'h0000_1234;
      #1;
      vectors++;
      if ({dbg_ready, rf_we} !== 2'b10) begin
         miscompares++;
         $display("FAIL reg0_dbg: got %b expected 10", {dbg_ready, rf_we});
      end
      @(negedge clk);
      dbg_valid = 1'b0;
      core_we   = 1'b1;
      core_addr = 5'd0;
      core_data = 32'h0000_5678;
      #1;
      vectors++;
      if ({core_stall, rf_we} !== 2'b00) begin
         miscompares++;
         $display("FAIL reg0_core: got %b expected 00", {core_stall, rf_we});
      end
      @(negedge clk);
      core_we = 1'b0;
   endtask

   task automatic test_core_priority;
      logic [40:0] obs, exp;
      @(negedge clk);
      core_we   = 1'b1;
      core_addr = 5'd8;
      core_data = 32'hDEAD_BEEF;
      dbg_valid = 1'b1;
      dbg_addr  = 5'd9;
      dbg_data  = 32'h0000_0055;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 6) dbg_valid = 1'b0;
         #1;
         obs = {rf_we, rf_addr, rf_data, core_stall, dbg_ready, mdu_ready};
         if (c == 5) exp = {1'b1, 5'd9, 32'h0000_0055, 3'b110};
         else        exp = {1'b1, 5'd8, 32'hDEAD_BEEF, 3'b000};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL core_priority cycle %0d: got %h expected %h", c, obs, exp);
         end
      end
      @(negedge clk);
      core_we = 1'b0;
   endtask

   task automatic test_limit0;
      logic [40:0] obs, exp;
      @(negedge clk);
      l0_core_we   = 1'b1;
      l0_core_addr = 5'd3;
      l0_core_data = 32'hCAFE_0003;
      l0_mdu_valid = 1'b1;
      l0_mdu_addr  = 5'd7;
      l0_mdu_data  = 32'h0BAD_0007;
      #1;
      obs = {l0_rf_we, l0_rf_addr, l0_rf_data, l0_core_stall, l0_mdu_ready, l0_dbg_ready};
      exp = {1'b1, 5'd7, 32'h0BAD_0007, 3'b110};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL limit0_side: got %h expected %h", obs, exp);
      end
      @(negedge clk);
      l0_mdu_valid = 1'b0;
      #1;
      obs = {l0_rf_we, l0_rf_addr, l0_rf_data, l0_core_stall, l0_mdu_ready, l0_dbg_ready};
      exp = {1'b1, 5'd3, 32'hCAFE_0003, 3'b000};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL limit0_core: got %h expected %h", obs, exp);
      end
      @(negedge clk);
      l0_core_we = 1'b0;
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b1;
      core_we      = 1'b0; core_addr    = 5'd0; core_data    = 32'd0;
      dbg_valid    = 1'b0; dbg_addr     = 5'd0; dbg_data     = 32'd0;
      mdu_valid    = 1'b0; mdu_addr     = 5'd0; mdu_data     = 32'd0;
      l0_core_we   = 1'b0; l0_core_addr = 5'd0; l0_core_data = 32'd0;
      l0_dbg_valid = 1'b0; l0_dbg_addr  = 5'd0; l0_dbg_data  = 32'd0;
      l0_mdu_valid = 1'b0; l0_mdu_addr  = 5'd0; l0_mdu_data  = 32'd0;
      test_reset();
      test_mid_init_reset();
      test_round_robin();
      test_reg0();
      test_core_priority();
      test_limit0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- After reset, a clear sequencer writes CLEAR_VAL to registers 1..31.
- Afterwards it arbitrates three requesters onto the write port:
  - core writeback, highest priority, no handshake, stallable;
  - debug/loader port, valid/ready;
  - multiply/divide unit result, valid/ready.
- A starvation counter stalls the core so the side requesters always make progress.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- CLEAR_VAL, 32'h0000_0000, value written to registers 1..31 during init
- STARVE_LIMIT, 4, consecutive core grants allowed while a side request waits; range 0..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- core_we  in  1  core writeback request
- core_addr  in  ADDR_W  core destination register
- core_data  in  DATA_W  core write data
- core_stall  out  1  core must hold its writeback and pipeline this cycle
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug write accepted this cycle
- dbg_addr  in  ADDR_W  debug destination register
- dbg_data  in  DATA_W  debug write data
- mdu_valid  in  1  MDU result write request
- mdu_ready  out  1  MDU write accepted this cycle
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU write data
- rf_we  out  1  to register file WE3
- rf_addr  out  ADDR_W  to register file A3
- rf_data  out  DATA_W  to register file WD3
- init_done  out  1  clear sequence complete

Behaviour:
- Registered state:
  - fsm: INIT, RUN
  - clr_idx: 5 bit
  - rr_ptr: DBG or MDU
  - starve: 4 bit
- All rf_*, ready and stall outputs are combinational from registered state and the current inputs. Write latency is zero: the register file captures the write at the same clk edge.
- Reset: a clk edge with rst_n=0 sets fsm=INIT, clr_idx=1, rr_ptr=DBG, starve=0.
  - While in INIT (including any reset cycle): init_done=0, core_stall=1, dbg_ready=0, mdu_ready=0.
  - Reset asserted mid-INIT restarts clearing from register 1.
  - Reset in RUN returns to INIT; the rf outputs follow the INIT rule below.
- INIT state:
  - Each cycle: rf_we=1, rf_addr=clr_idx, rf_data=CLEAR_VAL.
  - On each edge with rst_n=1, clr_idx increments.
  - The edge that writes register 31 moves fsm to RUN. Total is 31 write cycles; init_done=1 from the following cycle on.
  - Core and side requests are ignored; side requests stay pending.
- RUN, per-cycle grant (exactly one source or none):
  1. core_stall = (starve >= STARVE_LIMIT) && (dbg_valid || mdu_valid).
  2. If core_we && !core_stall, grant the core. dbg_ready=0, mdu_ready=0.
  3. Else if only one side is valid, grant it.
  4. Else if both sides are valid, grant the side named by rr_ptr.
  5. The granted side sees ready=1; the transfer occurs on valid&&ready at the edge.
  6. After a side grant, rr_ptr points to the other side.
  7. With no grant: rf_we=0; rf_addr and rf_data are don't-care and are driven 0.
- Starvation counter:
  - Increments (saturating at 15) on an edge where the core was granted and any side was valid.
  - Clears on a side grant, or on a cycle with no side valid.
- When core_stall=1 the core holds core_we, core_addr and core_data; the arbiter grants a side that cycle.
- STARVE_LIMIT=0 gives side requesters absolute priority.
- Register 0: a grant with address 0 drives rf_we=0. The handshake still completes, and counters and rr_ptr update normally.
- Side requesters hold addr and data stable while valid && !ready. Dropping valid before ready is allowed (the request is withdrawn).
- Two requests to the same register are serialised in grant order; the last one granted wins.

Test Plan:
- Reset clear: hold rst_n=0 for 3 cycles, then release → rf_we=1 with rf_addr 1,2,...,31 on consecutive cycles, rf_data=0. init_done rises on cycle 32; core_stall=0 afterwards.
- Reset mid-init: assert rst_n=0 after rf_addr=10 has been issued → after release, clearing restarts at rf_addr=1 and takes a full 31 cycles.
- Core priority: in RUN, core_we=1 to addr 8 with data 0xDEADBEEF, dbg_valid=1 to addr 9, STARVE_LIMIT=4 → core is written on 4 consecutive cycles. On the 5th cycle core_stall=1, dbg_ready=1, rf_addr=9. On the 6th cycle the core is granted again.
- Round robin: core idle; dbg_valid and mdu_valid both held with 3 requests each → grants alternate DBG, MDU, DBG, MDU, DBG, MDU, with one write per cycle and no bubbles.
- Register 0: dbg write to addr 0 with data 0x1234 → dbg_ready=1, rf_we=0; a subsequent core write to addr 0 also gives rf_we=0.
- Limit 0: STARVE_LIMIT=0, core_we=1 and mdu_valid=1 → core_stall=1 and mdu_ready=1 in the same cycle; the core is granted the next cycle once mdu_valid drops.
